fix_sink_list: RTL and testbench
================================

// Module: fix_sink_list
// PURPOSE
//  Upstream stage of the cluster-aggregation chain. On start, walks every neighbour's sinkIDs list in
//  shared memory, builds the de-duplicated union of sink IDs into the knownSinks table, writes
//  knownSinkCount, then raises done_fixSinkList, which gates the neighbour-sink/other-cluster check.
//  Sole memory master while busy; shares the single-port mem (1-cycle synchronous read).
// PARAMETERS
//  WORD_WIDTH      16      memory word width
//  ADDR_WIDTH      11      byte address width (word n at byte address 2n-aligned)
//  MAX_SINKS       16      knownSinks capacity
//  MAX_NEIGHBORS   64      neighbour table capacity
//  SINKS_PER_NBR   8       sinkIDs slots per neighbour
//  KNOWN_SINKS_BASE 11'h008, SINK_IDS_BASE 11'h248, KSINK_CNT_ADDR 11'h688,
//  NBR_CNT_ADDR 11'h68A, SINKID_CNT_BASE 11'h68E   fixed memory map
// PORTS
//  clock             in   1    system clock, rising edge
//  rst               in   1    asynchronous, active-high reset
//  en                in   1    start pulse; sampled only in IDLE/DONE
//  address           out  11   memory byte address
//  wr_en             out  1    memory write strobe (one cycle per write)
//  mem_data_out      in   16   memory read data, valid cycle after address issued
//  mem_data_in       out  16   memory write data
//  known_sink_count  out  5    final union size 0..16
//  sink_overflow     out  1    sticky: a new ID was dropped because table full
//  done_fixSinkList  out  1    level; high from completion until next accepted en
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, internal table/counters cleared; reset mid-run aborts with no
//   further writes (partially written table left in memory, count not written).
//  FSM: IDLE -> RD_NCNT -> W_NCNT -> [per nbr n] RD_SCNT -> W_SCNT -> [per slot k] RD_SID -> W_SID ->
//   (APPEND | skip) -> ... -> WR_KCNT -> DONE. DONE behaves as IDLE for en (restart clears done same edge).
//  Read = 2 cycles: RD_x drives address, W_x captures mem_data_out. wr_en 0 in all read states.
//  Addresses: nbrCount @0x68A; sinkIDCount[n] @0x68E+2n; sinkID[n][k] @0x248+16n+2k;
//   knownSinks[i] @0x008+2i; knownSinkCount @0x688.
//  Clamps: neighbour count >64 -> 64; per-neighbour count >8 -> 8; count 0 skips loop entirely.
//  Dedup: captured ID compared combinationally against all valid entries of 16x16 internal table;
//   match -> skip (no write). No match and count<16 -> APPEND: one cycle wr_en=1,
//   address=0x008+2*count, mem_data_in=ID, table[count]<=ID, count++. No match and count==16 ->
//   sink_overflow<=1, drop. Duplicates within one neighbour's list handled identically.
//  WR_KCNT: one cycle wr_en=1, address=0x688, mem_data_in=zero-extended count; next edge DONE,
//   done_fixSinkList=1, known_sink_count valid. en while busy ignored.
//  Cycle count from en edge: 2 + N*2 + sum_n(2*S_n) + appends + 1 write + 1 to done.
//  Table and overflow cleared on each accepted en, not on done.
// STRUCTURE
//  Shared package/include: WORD_WIDTH, ADDR_WIDTH, full memory-map base constants, table sizes
//   (same constants used by neighbour-sink stage and mem).
//  One sub-module natural: sink_table_cam (16x16 regs, parallel match, append port, count, clear).
//  Top: FSM, nbr/slot counters, address mux, write-data mux.
// TESTING
//  nbrCount=0, en pulse -> single write 0x688<=0, done after 4 cycles, count=0, no other wr_en.
//  nbr0 sinks {5,7}, nbr1 {7,9} -> knownSinks[0..2]={5,7,9}, 0x688<=3, exactly 4 writes.
//  one nbr with sinkIDCount=12, IDs all 3 -> only 8 reads of sinkIDs, one append, count=1.
//  3 nbrs x 8 unique IDs (24) -> first 16 stored in order, sink_overflow=1, 0x688<=16.
//  rst asserted mid-scan -> outputs 0 immediately (async), no further wr_en; new en -> clean rerun.
//  en pulsed while busy and again in DONE -> first ignored, second restarts, done drops same edge.

Source files
------------

// File: rtl/fix_sink_list_pkg.sv
// Shared constants for the cluster-aggregation chain: memory map, table sizes, FSM encoding
// and small address/clamp helpers.
package fix_sink_list_pkg;

  localparam int unsigned WORD_WIDTH    = 16;
  localparam int unsigned ADDR_WIDTH    = 11;
  localparam int unsigned MAX_SINKS     = 16;
  localparam int unsigned MAX_NEIGHBORS = 64;
  localparam int unsigned SINKS_PER_NBR = 8;

  localparam int unsigned CNT_WIDTH  = 5;
  localparam int unsigned IDX_WIDTH  = 4;
  localparam int unsigned NBR_WIDTH  = 7;
  localparam int unsigned SLOT_WIDTH = 4;

  localparam logic [ADDR_WIDTH-1:0] KNOWN_SINKS_BASE = 11'h008;
  localparam logic [ADDR_WIDTH-1:0] SINK_IDS_BASE    = 11'h248;
  localparam logic [ADDR_WIDTH-1:0] KSINK_CNT_ADDR   = 11'h688;
  localparam logic [ADDR_WIDTH-1:0] NBR_CNT_ADDR     = 11'h68A;
  localparam logic [ADDR_WIDTH-1:0] SINKID_CNT_BASE  = 11'h68E;

  typedef enum logic [3:0] {
    StIdle,
    StRdNcnt,
    StWNcnt,
    StRdScnt,
    StWScnt,
    StRdSid,
    StWSid,
    StAppend,
    StWrKcnt,
    StDone
  } fsl_state_e;

  function automatic logic [NBR_WIDTH-1:0] clamp_nbr(input logic [WORD_WIDTH-1:0] v);
    return (v > WORD_WIDTH'(MAX_NEIGHBORS)) ? NBR_WIDTH'(MAX_NEIGHBORS) : v[NBR_WIDTH-1:0];
  endfunction

  function automatic logic [SLOT_WIDTH-1:0] clamp_slot(input logic [WORD_WIDTH-1:0] v);
    return (v > WORD_WIDTH'(SINKS_PER_NBR)) ? SLOT_WIDTH'(SINKS_PER_NBR) : v[SLOT_WIDTH-1:0];
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] scnt_addr(input logic [NBR_WIDTH-1:0] n);
    return SINKID_CNT_BASE + {3'b000, n, 1'b0};
  endfunction

  // n never exceeds 63 while scanning, so n<<4 stays inside the 11-bit space.
  function automatic logic [ADDR_WIDTH-1:0] sid_addr(input logic [NBR_WIDTH-1:0] n,
                                                     input logic [SLOT_WIDTH-1:0] k);
    return SINK_IDS_BASE + {n, 4'b0000} + {6'b000000, k, 1'b0};
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] ks_addr(input logic [CNT_WIDTH-1:0] c);
    return KNOWN_SINKS_BASE + {5'b00000, c, 1'b0};
  endfunction

endpackage

// File: rtl/fix_sink_list_cam.sv
// Small CAM holding the de-duplicated sink IDs: parallel match against valid entries,
// in-order append, clear on restart.
module fix_sink_list_cam
  import fix_sink_list_pkg::*;
(
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_append,
  input  logic [WORD_WIDTH-1:0] i_id,
  input  logic [WORD_WIDTH-1:0] i_query,
  output logic                  o_match,
  output logic                  o_full,
  output logic [CNT_WIDTH-1:0]  o_count
);

  logic [WORD_WIDTH-1:0] r_table [MAX_SINKS];
  logic [CNT_WIDTH-1:0]  r_count;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      for (int i = 0; i < int'(MAX_SINKS); i++) r_table[i] <= '0;
    end else if (i_clear) begin
      r_count <= '0;
      for (int i = 0; i < int'(MAX_SINKS); i++) r_table[i] <= '0;
    end else if (i_append && !o_full) begin
      r_table[r_count[IDX_WIDTH-1:0]] <= i_id;
      r_count                         <= r_count + 1'b1;
    end
  end

  always_comb begin
    o_match = 1'b0;
    for (int i = 0; i < int'(MAX_SINKS); i++) begin
      if ((CNT_WIDTH'(i) < r_count) && (r_table[i] == i_query)) o_match = 1'b1;
    end
  end

  assign o_full  = (r_count == CNT_WIDTH'(MAX_SINKS));
  assign o_count = r_count;

endmodule

// File: rtl/fix_sink_list.sv
// Walks every neighbour's sinkIDs list in shared memory and builds the de-duplicated
// knownSinks table plus its count, then holds done until the next accepted start.
module fix_sink_list
  import fix_sink_list_pkg::*;
(
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  en,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  wr_en,
  input  logic [WORD_WIDTH-1:0] mem_data_out,
  output logic [WORD_WIDTH-1:0] mem_data_in,
  output logic [CNT_WIDTH-1:0]  known_sink_count,
  output logic                  sink_overflow,
  output logic                  done_fixSinkList
);

  fsl_state_e r_state, w_next;

  logic [NBR_WIDTH-1:0]  r_ncnt, r_nbr, w_ncnt_in;
  logic [SLOT_WIDTH-1:0] r_scnt, r_slot, w_scnt_in;
  logic [WORD_WIDTH-1:0] r_sid;
  logic                  r_overflow;
  logic                  w_accept, w_match, w_full, w_append, w_new_id, w_advance;
  logic                  w_last_slot, w_last_nbr;
  logic [CNT_WIDTH-1:0]  w_count;

  assign w_accept    = en && ((r_state == StIdle) || (r_state == StDone));
  assign w_ncnt_in   = clamp_nbr(mem_data_out);
  assign w_scnt_in   = clamp_slot(mem_data_out);
  assign w_append    = (r_state == StAppend);
  assign w_new_id    = (r_state == StWSid) && !w_match;
  assign w_advance   = ((r_state == StWSid) && (w_match || w_full)) || w_append;
  assign w_last_slot = ((r_slot + SLOT_WIDTH'(1)) == r_scnt);
  assign w_last_nbr  = ((r_nbr + NBR_WIDTH'(1)) == r_ncnt);

  fix_sink_list_cam u_cam (
    .clock    (clock),
    .rst      (rst),
    .i_clear  (w_accept),
    .i_append (w_append),
    .i_id     (r_sid),
    .i_query  (mem_data_out),
    .o_match  (w_match),
    .o_full   (w_full),
    .o_count  (w_count)
  );

  always_ff @(posedge clock or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      StIdle, StDone: if (en) w_next = StRdNcnt;
      StRdNcnt:       w_next = StWNcnt;
      StWNcnt:        w_next = (w_ncnt_in == '0) ? StWrKcnt : StRdScnt;
      StRdScnt:       w_next = StWScnt;
      StWScnt: begin
        if (w_scnt_in != '0) w_next = StRdSid;
        else                 w_next = w_last_nbr ? StWrKcnt : StRdScnt;
      end
      StRdSid:        w_next = StWSid;
      StWSid, StAppend: begin
        if (w_new_id && !w_full)  w_next = StAppend;
        else if (!w_last_slot)    w_next = StRdSid;
        else                      w_next = w_last_nbr ? StWrKcnt : StRdScnt;
      end
      StWrKcnt:       w_next = StDone;
      default:        w_next = StIdle;
    endcase
  end

  always_comb begin
    address          = '0;
    wr_en            = 1'b0;
    mem_data_in      = '0;
    done_fixSinkList = 1'b0;
    unique case (r_state)
      StRdNcnt: address = NBR_CNT_ADDR;
      StRdScnt: address = scnt_addr(r_nbr);
      StRdSid:  address = sid_addr(r_nbr, r_slot);
      StAppend: begin
        wr_en       = 1'b1;
        address     = ks_addr(w_count);
        mem_data_in = r_sid;
      end
      StWrKcnt: begin
        wr_en       = 1'b1;
        address     = KSINK_CNT_ADDR;
        mem_data_in = {{(WORD_WIDTH - CNT_WIDTH){1'b0}}, w_count};
      end
      StDone:   done_fixSinkList = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_ncnt     <= '0;
      r_nbr      <= '0;
      r_scnt     <= '0;
      r_slot     <= '0;
      r_sid      <= '0;
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      r_ncnt     <= '0;
      r_nbr      <= '0;
      r_scnt     <= '0;
      r_slot     <= '0;
      r_sid      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (r_state == StWNcnt) begin
        r_ncnt <= w_ncnt_in;
        r_nbr  <= '0;
      end
      if (r_state == StWScnt) begin
        r_scnt <= w_scnt_in;
        r_slot <= '0;
        if (w_scnt_in == '0) r_nbr <= r_nbr + NBR_WIDTH'(1);
      end
      if (r_state == StWSid) r_sid <= mem_data_out;
      if (w_new_id && w_full) r_overflow <= 1'b1;
      if (w_advance) begin
        if (w_last_slot) r_nbr  <= r_nbr + NBR_WIDTH'(1);
        else             r_slot <= r_slot + SLOT_WIDTH'(1);
      end
    end
  end

  assign known_sink_count = w_count;
  assign sink_overflow    = r_overflow;

endmodule

// File: tb/tb_fix_sink_list.sv
// Bench for fix_sink_list: word-addressed memory fixture, queue-based union model of the
// expected writes, latency and final table contents.
module tb_fix_sink_list;

  logic        clock, rst, en;
  logic [10:0] address;
  logic        wr_en;
  logic [15:0] mem_data_out, mem_data_in;
  logic [4:0]  known_sink_count;
  logic        sink_overflow, done_fixSinkList;

  fix_sink_list dut (
    .clock            (clock),
    .rst              (rst),
    .en               (en),
    .address          (address),
    .wr_en            (wr_en),
    .mem_data_out     (mem_data_out),
    .mem_data_in      (mem_data_in),
    .known_sink_count (known_sink_count),
    .sink_overflow    (sink_overflow),
    .done_fixSinkList (done_fixSinkList)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Word index = byte address / 2.
  localparam int W_KS   = 'h004;
  localparam int W_SIDS = 'h124;
  localparam int W_KCNT = 'h344;
  localparam int W_NCNT = 'h345;
  localparam int W_SCNT = 'h347;

  logic [15:0] mem [1024];
  logic [15:0] img [1024];
  logic        load;

  always @(posedge clock) begin
    if (load) mem <= img;
    else if (wr_en) mem[address[10:1]] <= mem_data_in;
    mem_data_out <= mem[address[10:1]];
  end

  int          n_cmp, n_err;
  logic [26:0] exp_q[$];
  int          exp_list[$];
  int          exp_lat, exp_cnt, exp_ovf, exp_sid;
  int          sid_reads, n_wr;
  bit          mon_on;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // One cycle: sample at the falling edge and compare writes against the model.
  task automatic tick();
    logic [26:0] e;
    @(negedge clock);
    if (rst) begin
      chk("wr_en_in_reset", int'(wr_en), 0);
    end else if (mon_on) begin
      if (wr_en) begin
        n_wr++;
        chk("write_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("wr_addr", int'(address), int'(e[26:16]));
          chk("wr_data", int'(mem_data_in), int'(e[15:0]));
        end
      end else if (address >= 11'h248 && address < 11'h648) begin
        sid_reads++;
      end
    end
  endtask

  // Union of all neighbour lists, first-come order, capped at 16.
  task automatic model();
    int n_nbr, s, id;
    bit found;
    exp_q.delete();
    exp_list.delete();
    n_nbr   = (img[W_NCNT] > 16'd64) ? 64 : int'(img[W_NCNT]);
    exp_lat = 2 + 2 * n_nbr;
    exp_sid = 0;
    exp_ovf = 0;
    for (int n = 0; n < n_nbr; n++) begin
      s = (img[W_SCNT + n] > 16'd8) ? 8 : int'(img[W_SCNT + n]);
      exp_lat += 2 * s;
      for (int k = 0; k < s; k++) begin
        id = int'(img[W_SIDS + 8 * n + k]);
        exp_sid++;
        found = 0;
        foreach (exp_list[i]) if (exp_list[i] == id) found = 1;
        if (!found) begin
          if (exp_list.size() < 16) begin
            exp_q.push_back({11'(8 + 2 * exp_list.size()), 16'(id)});
            exp_list.push_back(id);
            exp_lat++;
          end else begin
            exp_ovf = 1;
          end
        end
      end
    end
    exp_cnt = exp_list.size();
    exp_q.push_back({11'h688, 16'(exp_cnt)});
    exp_lat += 2;
  endtask

  task automatic fill_garbage();
    for (int i = 0; i < 1024; i++) img[i] = 16'($urandom);
  endtask

  task automatic load_img();
    load = 1'b1;
    @(posedge clock);
    #1 load = 1'b0;
    tick();
  endtask

  task automatic run(input int pulse_at, output int got);
    model();
    n_wr      = 0;
    sid_reads = 0;
    mon_on    = 1;
    got       = 0;
    en        = 1'b1;
    for (int j = 1; j <= 3000; j++) begin
      tick();
      en = (j == pulse_at);
      if (done_fixSinkList) begin
        got = j;
        break;
      end
    end
    en = 1'b0;
    #1;
    chk("latency", got, exp_lat);
    chk("writes_left", exp_q.size(), 0);
    chk("known_sink_count", int'(known_sink_count), exp_cnt);
    chk("sink_overflow", int'(sink_overflow), exp_ovf);
    chk("sid_reads", sid_reads, exp_sid);
    chk("mem_kcnt", int'(mem[W_KCNT]), exp_cnt);
    foreach (exp_list[i]) chk("mem_known_sink", int'(mem[W_KS + i]), exp_list[i]);
    mon_on = 0;
  endtask

  task automatic setup_two();
    fill_garbage();
    img[W_NCNT]       = 16'd2;
    img[W_SCNT + 0]   = 16'd2;
    img[W_SCNT + 1]   = 16'd2;
    img[W_SIDS + 0]   = 16'd5;
    img[W_SIDS + 1]   = 16'd7;
    img[W_SIDS + 8]   = 16'd7;
    img[W_SIDS + 9]   = 16'd9;
    load_img();
  endtask

  initial begin
    int got, n_nbr;
    n_cmp  = 0;
    n_err  = 0;
    mon_on = 0;
    load   = 1'b0;
    en     = 1'b0;
    rst    = 1'b1;
    for (int i = 0; i < 1024; i++) img[i] = '0;
    tick();
    tick();
    chk("reset_wr_en", int'(wr_en), 0);
    chk("reset_address", int'(address), 0);
    chk("reset_data", int'(mem_data_in), 0);
    chk("reset_count", int'(known_sink_count), 0);
    chk("reset_ovf", int'(sink_overflow), 0);
    chk("reset_done", int'(done_fixSinkList), 0);
    rst = 1'b0;
    load_img();

    // No neighbours: only the count write.
    fill_garbage();
    img[W_NCNT] = 16'd0;
    load_img();
    run(0, got);
    chk("t1_latency_lit", got, 4);
    chk("t1_writes_lit", n_wr, 1);
    chk("t1_count_lit", int'(known_sink_count), 0);

    // {5,7} + {7,9}
    setup_two();
    run(0, got);
    chk("t2_ks0", int'(mem[W_KS + 0]), 5);
    chk("t2_ks1", int'(mem[W_KS + 1]), 7);
    chk("t2_ks2", int'(mem[W_KS + 2]), 9);
    chk("t2_kcnt", int'(mem[W_KCNT]), 3);
    chk("t2_writes_lit", n_wr, 4);

    // Per-neighbour count clamp with all-duplicate IDs.
    fill_garbage();
    img[W_NCNT]     = 16'd1;
    img[W_SCNT + 0] = 16'd12;
    for (int k = 0; k < 12; k++) img[W_SIDS + k] = 16'd3;
    load_img();
    run(0, got);
    chk("t3_sid_reads_lit", sid_reads, 8);
    chk("t3_count_lit", int'(known_sink_count), 1);

    // 24 unique IDs overflow the 16-entry table.
    fill_garbage();
    img[W_NCNT] = 16'd3;
    for (int n = 0; n < 3; n++) begin
      img[W_SCNT + n] = 16'd8;
      for (int k = 0; k < 8; k++) img[W_SIDS + 8 * n + k] = 16'(100 + 8 * n + k);
    end
    load_img();
    run(0, got);
    chk("t4_count_lit", int'(known_sink_count), 16);
    chk("t4_ovf_lit", int'(sink_overflow), 1);
    chk("t4_last_lit", int'(mem[W_KS + 15]), 115);

    // Overflow must clear on the next start.
    setup_two();
    run(0, got);
    chk("t5_ovf_cleared_lit", int'(sink_overflow), 0);

    // Reset mid-scan, then a clean rerun.
    setup_two();
    en = 1'b1;
    tick();
    en = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    #3 rst = 1'b1;
    #1;
    chk("rst_async_wr_en", int'(wr_en), 0);
    chk("rst_async_address", int'(address), 0);
    chk("rst_async_done", int'(done_fixSinkList), 0);
    chk("rst_async_count", int'(known_sink_count), 0);
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b0;
    tick();
    run(0, got);

    // en while busy is ignored; en in DONE restarts and drops done on the same edge.
    setup_two();
    run(3, got);
    run(0, got);

    // Randomised neighbour tables, including neighbour-count clamp.
    for (int t = 0; t < 12; t++) begin
      fill_garbage();
      n_nbr = ($urandom_range(0, 3) == 0) ? $urandom_range(64, 74) : $urandom_range(0, 6);
      img[W_NCNT] = 16'(n_nbr);
      for (int n = 0; n < 64; n++) begin
        img[W_SCNT + n] = 16'($urandom_range(0, 11));
        for (int k = 0; k < 8; k++)
          img[W_SIDS + 8 * n + k] = (t % 2 == 0) ? 16'($urandom_range(0, 24)) : 16'($urandom);
      end
      load_img();
      run((t % 3 == 0) ? 4 : 0, got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
